router_wrap_ccff_loader: RTL and testbench

ROUTER_WRAP_CCFF_LOADER -- requirements
Module: router_wrap_ccff_loader

---
 rtl/router_wrap_ccff_loader.sv | 163 ++++++++++++++++
 tb/tb_router_wrap_ccff_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/router_wrap_ccff_loader.sv
// Streams host bitstream words into a configuration flip-flop chain: one bit per cycle, first bit lands deepest, no word-boundary bubbles.
// in_valid/in_ready handshake; shifting stalls while the buffer is empty. Define CCFF_READBACK_EN for tail/head parity readback (rb_err).
module router_wrap_ccff_loader #(
  parameter int CHAIN_LEN = 112,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              rb_err
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BIT_W = $clog2(WORD_W + 1);

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [BIT_W-1:0]  bits_q, bits_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;
  logic              done_q, done_d;

  logic              load_st;
  logic              shift;
  logic              last_shift;
  logic              accept;
  logic              can_take;
  logic [31:0]       rem;
  logic [31:0]       take;

  always_ff @(posedge prog_clk) begin
    if (!pReset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (last_shift) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_st       = (state_q == LOAD);
    shift         = load_st && (bits_q != '0);
    last_shift    = shift && (shift_cnt_q == CNT_W'(CHAIN_LEN - 1));
    can_take      = (acc_q < CNT_W'(CHAIN_LEN));
    in_ready      = load_st && (!shift || (bits_q == BIT_W'(1))) && can_take;
    accept        = in_valid && in_ready;
    ccff_head     = shift && buf_q[0];
    ccff_shift_en = shift;
    busy          = load_st;
    done          = done_q;
  end

  // A word only loads as many bits as the chain still needs, so overflow bits are never shifted.
  always_comb begin
    rem         = 32'(CHAIN_LEN) - 32'(acc_q);
    take        = (rem < 32'(WORD_W)) ? rem : 32'(WORD_W);
    buf_d       = buf_q;
    bits_d      = bits_q;
    acc_d       = acc_q;
    shift_cnt_d = shift_cnt_q;
    done_d      = last_shift;
    if (!load_st) begin
      buf_d       = '0;
      bits_d      = '0;
      acc_d       = '0;
      shift_cnt_d = '0;
    end else begin
      if (shift) begin
        buf_d       = buf_q >> 1;
        bits_d      = bits_q - BIT_W'(1);
        shift_cnt_d = shift_cnt_q + CNT_W'(1);
      end
      if (accept) begin
        buf_d  = in_data;
        bits_d = BIT_W'(take);
        acc_d  = acc_q + CNT_W'(take);
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      buf_q       <= '0;
      bits_q      <= '0;
      acc_q       <= '0;
      shift_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      bits_q      <= bits_d;
      acc_q       <= acc_d;
      shift_cnt_q <= shift_cnt_d;
      done_q      <= done_d;
    end
  end

`ifdef CCFF_READBACK_EN
  logic head_par_q, head_par_d;
  logic tail_par_q, tail_par_d;
  logic prev_par_q, prev_par_d;
  logic have_prev_q, have_prev_d;
  logic rb_err_q, rb_err_d;

  // The tail streams out the previous load, so its parity is judged against the previous head parity.
  always_comb begin
    head_par_d  = head_par_q;
    tail_par_d  = tail_par_q;
    prev_par_d  = prev_par_q;
    have_prev_d = have_prev_q;
    rb_err_d    = rb_err_q;
    if (!load_st) begin
      head_par_d = 1'b0;
      tail_par_d = 1'b0;
    end else if (shift) begin
      head_par_d = head_par_q ^ ccff_head;
      tail_par_d = tail_par_q ^ ccff_tail;
    end
    if (last_shift) begin
      rb_err_d    = have_prev_q && (tail_par_d != prev_par_q);
      prev_par_d  = head_par_d;
      have_prev_d = 1'b1;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      head_par_q  <= 1'b0;
      tail_par_q  <= 1'b0;
      prev_par_q  <= 1'b0;
      have_prev_q <= 1'b0;
      rb_err_q    <= 1'b0;
    end else begin
      head_par_q  <= head_par_d;
      tail_par_q  <= tail_par_d;
      prev_par_q  <= prev_par_d;
      have_prev_q <= have_prev_d;
      rb_err_q    <= rb_err_d;
    end
  end

  assign rb_err = rb_err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign rb_err      = 1'b0;
`endif

endmodule

// File: tb/tb_router_wrap_ccff_loader.sv
// Directed bench for router_wrap_ccff_loader: a 112-bit and a 100-bit instance, each driving a behavioural chain model.
module tb_router_wrap_ccff_loader;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic       p_reset_n, start, in_valid, sel, inv;
  logic [7:0] in_data;

  logic start_a, start_b, vld_a, vld_b;
  logic rdy_a, head_a, sen_a, tail_a, busy_a, done_a, err_a;
  logic rdy_b, head_b, sen_b, tail_b, busy_b, done_b, err_b;
  logic m_rdy, m_head, m_sen, m_busy, m_done, m_err;

  logic [111:0] chain_a = '0;
  logic [111:0] chain_b = '0;
  int           tidx    = 0;

  int n_cmp = 0;
  int n_bad = 0;

  int r_shifts, r_first, r_last, r_done_cyc, r_done_cnt, r_gaps, r_gaps_rdy, r_accepted;
  logic r_busy_done, r_head0, r_ready_late, r_rst_hit, r_rb;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign vld_a   = in_valid & ~sel;
  assign vld_b   = in_valid & sel;

  assign m_rdy  = sel ? rdy_b  : rdy_a;
  assign m_head = sel ? head_b : head_a;
  assign m_sen  = sel ? sen_b  : sen_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  assign m_err  = sel ? err_b  : err_a;

  assign tail_a = chain_a[111] ^ (inv & ~sel & (tidx == 10));
  assign tail_b = chain_b[99]  ^ (inv &  sel & (tidx == 10));

  router_wrap_ccff_loader #(.CHAIN_LEN(112), .WORD_W(8)) u_dut_a (
    .prog_clk(prog_clk), .pReset_n(p_reset_n), .start(start_a), .in_data(in_data),
    .in_valid(vld_a), .in_ready(rdy_a), .ccff_head(head_a), .ccff_shift_en(sen_a),
    .ccff_tail(tail_a), .busy(busy_a), .done(done_a), .rb_err(err_a)
  );

  router_wrap_ccff_loader #(.CHAIN_LEN(100), .WORD_W(8)) u_dut_b (
    .prog_clk(prog_clk), .pReset_n(p_reset_n), .start(start_b), .in_data(in_data),
    .in_valid(vld_b), .in_ready(rdy_b), .ccff_head(head_b), .ccff_shift_en(sen_b),
    .ccff_tail(tail_b), .busy(busy_b), .done(done_b), .rb_err(err_b)
  );

  // Chain model: head enters position 0 and moves toward CHAIN_LEN-1 on each enabled edge.
  always @(posedge prog_clk) begin
    if (sen_a) chain_a <= {chain_a[110:0], head_a};
    if (sen_b) chain_b <= {chain_b[110:0], head_b};
    if (start_a | start_b) tidx <= 0;
    else if (m_sen)        tidx <= tidx + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] wval(input int i, input logic [7:0] key);
    return 8'(i + 1) ^ key;
  endfunction

  task automatic chk_chain(input string tag, input int len, input logic [7:0] key, input logic [111:0] ch);
    int errs;
    logic [7:0] w;
    errs = 0;
    for (int k = 0; k < len; k++) begin
      w = wval(k / 8, key);
      if (ch[len - 1 - k] !== w[k % 8]) errs++;
    end
    chk(tag, errs, 0);
  endtask

  task automatic run_load(input int len, input int stall_after, input int rst_at, input logic [7:0] key);
    int  words, stall_left, cyc;
    bit  fin;
    r_shifts = 0; r_first = -1; r_last = -1; r_done_cyc = -1; r_done_cnt = 0;
    r_gaps = 0; r_gaps_rdy = 0; r_busy_done = 1'b1; r_head0 = 1'b0;
    r_ready_late = 1'b0; r_rst_hit = 1'b0; r_rb = 1'b0;
    words = 0; stall_left = 5; fin = 1'b0; cyc = 0;
    @(negedge prog_clk); start = 1'b1; in_valid = 1'b0;
    @(negedge prog_clk); start = 1'b0; cyc = 1;
    while (!fin && cyc < 400) begin
      if (m_sen) begin
        if (r_shifts == 0) begin r_first = cyc; r_head0 = m_head; end
        r_shifts++;
        r_last = cyc;
      end else if (r_shifts > 0 && m_busy) begin
        r_gaps++;
        if (m_rdy) r_gaps_rdy++;
      end
      if (m_done) begin
        r_done_cnt++; r_done_cyc = cyc; r_busy_done = m_busy; r_rb = m_err; fin = 1'b1;
      end
      if (m_rdy && words * 8 >= len) r_ready_late = 1'b1;
      if (!fin) begin
        if (rst_at > 0 && r_shifts == rst_at) begin
          p_reset_n = 1'b0; in_valid = 1'b0;
          @(negedge prog_clk);
          p_reset_n = 1'b1; r_rst_hit = 1'b1; fin = 1'b1;
        end else begin
          if (words >= 14 || (words == stall_after && stall_left > 0)) begin
            in_valid = 1'b0;
            if (words == stall_after && m_rdy) stall_left--;
          end else begin
            in_valid = 1'b1;
            in_data  = wval(words, key);
          end
          if (in_valid && m_rdy) words++;
          @(negedge prog_clk);
          cyc++;
        end
      end
    end
    in_valid   = 1'b0;
    r_accepted = words;
    if (!fin) chk("load_timeout", 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int dn;
    logic exp_rb;
    sel = 1'b0; inv = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; p_reset_n = 1'b0;
    repeat (2) @(negedge prog_clk);
    chk("reset_outputs", {rdy_a, head_a, sen_a, busy_a, done_a, err_a}, 0);
    p_reset_n = 1'b1;

    // Unstalled full load
    run_load(112, -1, -1, 8'h00);
    chk("full_shifts", r_shifts, 112);
    chk("full_first_shift_cyc", r_first, 2);
    chk("full_first_head", r_head0, 1);
    chk("full_last_shift_cyc", r_last, 113);
    chk("full_gaps", r_gaps, 0);
    chk("full_done_cyc", r_done_cyc, 114);
    chk("full_busy_at_done", r_busy_done, 0);
    chk("full_ready_after_last_word", r_ready_late, 0);
    chk_chain("full_chain", 112, 8'h00, chain_a);
    @(negedge prog_clk);
    chk("full_done_one_cycle", m_done, 0);

    // Five ready cycles with no data after the third word
    run_load(112, 3, -1, 8'h00);
    chk("stall_shifts", r_shifts, 112);
    chk("stall_gaps", r_gaps, 5);
    chk("stall_gaps_while_empty", r_gaps_rdy, 5);
    chk("stall_last_shift_cyc", r_last, 118);
    chk("stall_done_cyc", r_done_cyc, 119);
    chk_chain("stall_chain", 112, 8'h00, chain_a);

    // 100-bit chain: thirteenth word only partly used
    sel = 1'b1;
    run_load(100, -1, -1, 8'h00);
    chk("part_accepted", r_accepted, 13);
    chk("part_ready_after_13", r_ready_late, 0);
    chk("part_shifts", r_shifts, 100);
    chk("part_done_cyc", r_done_cyc, 102);
    chk_chain("part_chain", 100, 8'h00, chain_b);
    sel = 1'b0;

    // Idle reset, with a competing start in the same cycle
    @(negedge prog_clk); p_reset_n = 1'b0; start = 1'b1;
    @(negedge prog_clk); p_reset_n = 1'b1; start = 1'b0;
    chk("idle_reset_outputs", {rdy_a, head_a, sen_a, busy_a, done_a, err_a}, 0);

    // Reset after 50 shifts
    run_load(112, -1, 50, 8'h00);
    chk("midrst_hit", r_rst_hit, 1);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_shift_en", sen_a, 0);
    chk("midrst_ready", rdy_a, 0);
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      if (done_a || sen_a) dn++;
      @(negedge prog_clk);
    end
    chk("midrst_no_done_or_shift", dn, 0);

    // Readback: A, A, then B with one corrupted tail bit
`ifdef CCFF_READBACK_EN
    exp_rb = 1'b1;
`else
    exp_rb = 1'b0;
`endif
    run_load(112, -1, -1, 8'h00);
    chk("rb_first_load", r_rb, 0);
    run_load(112, -1, -1, 8'h00);
    chk("rb_repeat_load", r_rb, 0);
    inv = 1'b1;
    run_load(112, -1, -1, 8'hFF);
    inv = 1'b0;
    chk("rb_corrupt_tail", r_rb, exp_rb);
    chk_chain("rb_chain_b", 112, 8'hFF, chain_a);
    repeat (3) @(negedge prog_clk);
    chk("rb_err_held", err_a, exp_rb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
